// File: rtl/panda_mem_pkg.sv
// Shared definitions for the port-B data-memory arbiter.
//   size_e      : access size encoding carried on reqN_size_i
//   WE_*        : byte-lane write-enable patterns (low lanes of the word)
//   state_t     : sequencer state encoding plus its constants
//   access_err  : 1 when a size/alignment combination must be rejected
//   size_we     : lane pattern for a legal store of the given size
package panda_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    localparam logic [3:0] WE_WORD = 4'b1111;
    localparam logic [3:0] WE_HALF = 4'b0011;
    localparam logic [3:0] WE_BYTE = 4'b0001;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_RESP   = 2'd2;

    function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size_e'(size))
            SZ_BYTE: access_err = 1'b0;
            SZ_HALF: access_err = addr_lo[0];
            SZ_WORD: access_err = (addr_lo != 2'b00);
            default: access_err = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] size_we(input logic [1:0] size);
        case (size_e'(size))
            SZ_BYTE: size_we = WE_BYTE;
            SZ_HALF: size_we = WE_HALF;
            SZ_WORD: size_we = WE_WORD;
            default: size_we = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker.
//   clk, rstn_i : clock, async active-low reset
//   i_req[1:0]  : request vector (bit N = requester N)
//   i_update    : a grant was consumed this cycle; remember the winner
//   o_grant[1:0]: one-hot grant (all zero when nobody requests)
// On a tie the requester that did not win last time is picked. The history
// bit resets to 1 so requester 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rstn_i,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_grant
);

    logic r_last;

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = r_last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_last <= 1'b1;
        end else if (i_update) begin
            r_last <= o_grant[1];
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Arbiter and sequencer for port B of the shared dual-port data RAM.
// Requester 0 is the load/store unit, requester 1 the loader/debug master.
//   clk, rstn_i          : clock, async active-low reset
//   reqN_valid/ready     : request handshake (N = 0,1)
//   reqN_addr/we/size/wdata : byte address, store flag, size code, store data
//   rspN_valid/rdata/err : single-cycle response to the owning requester
//   ram_en/we/addr/din   : port-B controls; ram_dout_i is combinational read data
//
// state  | meaning
// IDLE   | waiting for a request, arbitration open
// ACCESS | latched request drives the RAM, read data captured at cycle end
// RESP   | response pulse to the owner, arbitration open for the next access
module dram_port_arbiter
    import panda_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_addr_i,
    input  logic        req0_we_i,
    input  logic [1:0]  req0_size_i,
    input  logic [31:0] req0_wdata_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_addr_i,
    input  logic        req1_we_i,
    input  logic [1:0]  req1_size_i,
    input  logic [31:0] req1_wdata_i,
    output logic        rsp0_valid_o,
    output logic [31:0] rsp0_rdata_o,
    output logic        rsp0_err_o,
    output logic        rsp1_valid_o,
    output logic [31:0] rsp1_rdata_o,
    output logic        rsp1_err_o,
    output logic        ram_en_o,
    output logic [3:0]  ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_din_o,
    input  logic [31:0] ram_dout_i
);

    state_t      r_state;
    logic        r_owner;
    logic        r_we;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_arb_en;
    logic [1:0]  w_grant;
    logic        w_sel;
    logic        w_hs;
    logic        w_acc;
    logic        w_acc_err;
    logic        w_legal;
    logic        w_rsp;

    // Readies are held low while reset is asserted so every output reads 0.
    assign w_arb_en = rstn_i && ((r_state == ST_IDLE) || (r_state == ST_RESP));

    rr_arb2 u_arb (
        .clk      (clk),
        .rstn_i   (rstn_i),
        .i_req    ({req1_valid_i, req0_valid_i}),
        .i_update (w_hs),
        .o_grant  (w_grant)
    );

    assign req0_ready_o = w_arb_en & w_grant[0];
    assign req1_ready_o = w_arb_en & w_grant[1];
    assign w_hs         = (req0_valid_i & req0_ready_o) | (req1_valid_i & req1_ready_o);
    assign w_sel        = w_grant[1];

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_hs) begin
                        r_owner <= w_sel;
                        r_we    <= w_sel ? req1_we_i    : req0_we_i;
                        r_size  <= w_sel ? req1_size_i  : req0_size_i;
                        r_addr  <= w_sel ? req1_addr_i  : req0_addr_i;
                        r_wdata <= w_sel ? req1_wdata_i : req0_wdata_i;
                        r_state <= ST_ACCESS;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    r_err   <= w_acc_err;
                    r_rdata <= (!w_acc_err && !r_we) ? ram_dout_i : '0;
                    r_state <= ST_RESP;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // RAM side is driven purely from the latched request.
    assign w_acc     = (r_state == ST_ACCESS);
    assign w_acc_err = access_err(r_size, r_addr[1:0]);
    assign w_legal   = w_acc & ~w_acc_err;

    assign ram_en_o   = w_legal;
    assign ram_we_o   = (w_legal && r_we) ? size_we(r_size) : 4'b0000;
    assign ram_addr_o = w_acc ? r_addr  : '0;
    assign ram_din_o  = w_acc ? r_wdata : '0;

    assign w_rsp        = (r_state == ST_RESP);
    assign rsp0_valid_o = w_rsp & ~r_owner;
    assign rsp1_valid_o = w_rsp &  r_owner;
    assign rsp0_rdata_o = rsp0_valid_o ? r_rdata : '0;
    assign rsp1_rdata_o = rsp1_valid_o ? r_rdata : '0;
    assign rsp0_err_o   = rsp0_valid_o & r_err;
    assign rsp1_err_o   = rsp1_valid_o & r_err;

endmodule

// File: tb/tb_dram_port_arbiter.sv
`timescale 1ns/1ps
module tb_dram_port_arbiter;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [31:0] req0_addr_i, req1_addr_i;
    logic        req0_we_i, req1_we_i;
    logic [1:0]  req0_size_i, req1_size_i;
    logic [31:0] req0_wdata_i, req1_wdata_i;
    logic        rsp0_valid_o, rsp1_valid_o;
    logic [31:0] rsp0_rdata_o, rsp1_rdata_o;
    logic        rsp0_err_o, rsp1_err_o;
    logic        ram_en_o;
    logic [3:0]  ram_we_o;
    logic [31:0] ram_addr_o, ram_din_o, ram_dout_i;

    always #5 clk = ~clk;

    dram_port_arbiter dut (
        .clk(clk), .rstn_i(rstn_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_addr_i(req0_addr_i),
        .req0_we_i(req0_we_i), .req0_size_i(req0_size_i), .req0_wdata_i(req0_wdata_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_addr_i(req1_addr_i),
        .req1_we_i(req1_we_i), .req1_size_i(req1_size_i), .req1_wdata_i(req1_wdata_i),
        .rsp0_valid_o(rsp0_valid_o), .rsp0_rdata_o(rsp0_rdata_o), .rsp0_err_o(rsp0_err_o),
        .rsp1_valid_o(rsp1_valid_o), .rsp1_rdata_o(rsp1_rdata_o), .rsp1_err_o(rsp1_err_o),
        .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_din_o(ram_din_o), .ram_dout_i(ram_dout_i)
    );

    // ---------------- environment RAM (what the DUT really talks to) ----------------
    function automatic logic [31:0] init_word(input int i);
        if (i == 17)      init_word = 32'h1122_3344;
        else if (i == 18) init_word = 32'hCAFE_F00D;
        else if (i == 32) init_word = 32'h55AA_55AA;
        else              init_word = 32'h9E37_79B9 * 32'(i + 1);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din, input logic [3:0] be);
        merge = old;
        for (int b = 0; b < 4; b++) if (be[b]) merge[b*8 +: 8] = din[b*8 +: 8];
    endfunction

    logic [31:0] env_ram [256];
    logic        mem_init;
    assign ram_dout_i = env_ram[ram_addr_o[9:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) env_ram[i] <= init_word(i);
        end else if (ram_en_o) begin
            env_ram[ram_addr_o[9:2]] <= merge(env_ram[ram_addr_o[9:2]], ram_din_o, ram_we_o);
        end
    end

    // ---------------- checking infrastructure ----------------
    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each accepted request becomes a transaction stamped with the cycle in
    // which it touches the RAM; the response follows one cycle later.
    typedef struct {
        int          id;
        logic [31:0] addr;
        bit          we;
        logic [1:0]  size;
        logic [31:0] wdata;
        int          acc_cyc;
        logic [31:0] rdata;
        bit          err;
    } txn_t;

    typedef struct { int id; int c; } ev_t;

    txn_t        q[$];
    bit          m_last;
    logic [31:0] ref_mem [256];
    ev_t         hs_log[$];
    ev_t         rsp_log[$];
    int          rsp_cnt;
    int          last_rsp_id;
    logic [31:0] last_rdata;
    bit          last_err;
    logic [3:0]  acc_we_seen;
    bit          acc_en_seen;

    function automatic bit m_illegal(input logic [1:0] size, input logic [31:0] addr);
        int nbytes;
        if (size == 2'd3) return 1'b1;
        nbytes = 1 << size;
        return (addr % nbytes) != 0;
    endfunction

    function automatic logic [3:0] m_mask(input logic [1:0] size);
        return 4'((1 << (1 << size)) - 1);
    endfunction

    task automatic check_cycle(output bit hs, output txn_t nt);
        int ia, ir, win;
        bit er0, er1, legal;
        ia = -1; ir = -1; win = 0; hs = 0;
        nt = '{default: '0};
        if (!rstn_i) begin
            q.delete();
            m_last = 1'b1;
            chk1("rst_ready0", req0_ready_o, 1'b0);
            chk1("rst_ready1", req1_ready_o, 1'b0);
            chk1("rst_ram_en", ram_en_o, 1'b0);
            chk32("rst_ram_we", 32'(ram_we_o), 32'h0);
            chk32("rst_ram_addr", ram_addr_o, 32'h0);
            chk32("rst_ram_din", ram_din_o, 32'h0);
            chk1("rst_rsp0_valid", rsp0_valid_o, 1'b0);
            chk1("rst_rsp1_valid", rsp1_valid_o, 1'b0);
            chk32("rst_rsp0_rdata", rsp0_rdata_o, 32'h0);
            chk32("rst_rsp1_rdata", rsp1_rdata_o, 32'h0);
            chk1("rst_rsp0_err", rsp0_err_o, 1'b0);
            chk1("rst_rsp1_err", rsp1_err_o, 1'b0);
            return;
        end
        foreach (q[i]) begin
            if (q[i].acc_cyc == cyc)     ia = i;
            if (q[i].acc_cyc + 1 == cyc) ir = i;
        end
        er0 = 1'b0; er1 = 1'b0;
        if (ia < 0) begin
            if (req0_valid_i && req1_valid_i) win = m_last ? 0 : 1;
            else if (req1_valid_i)            win = 1;
            else                              win = 0;
            hs  = req0_valid_i | req1_valid_i;
            er0 = hs && (win == 0);
            er1 = hs && (win == 1);
            if (hs) begin
                nt.id      = win;
                nt.addr    = win ? req1_addr_i  : req0_addr_i;
                nt.we      = win ? req1_we_i    : req0_we_i;
                nt.size    = win ? req1_size_i  : req0_size_i;
                nt.wdata   = win ? req1_wdata_i : req0_wdata_i;
                nt.acc_cyc = cyc + 1;
            end
        end
        chk1("ready0", req0_ready_o, er0);
        chk1("ready1", req1_ready_o, er1);
        if (ia >= 0) begin
            legal = !m_illegal(q[ia].size, q[ia].addr);
            chk1("ram_en", ram_en_o, legal);
            chk32("ram_we", 32'(ram_we_o), (legal && q[ia].we) ? 32'(m_mask(q[ia].size)) : 32'h0);
            if (legal) chk32("ram_addr", ram_addr_o, q[ia].addr);
            if (legal && q[ia].we) chk32("ram_din", ram_din_o, q[ia].wdata);
            acc_en_seen = ram_en_o;
            acc_we_seen = ram_we_o;
        end else begin
            chk1("ram_en_idle", ram_en_o, 1'b0);
            chk32("ram_we_idle", 32'(ram_we_o), 32'h0);
        end
        chk1("rsp0_valid", rsp0_valid_o, (ir >= 0) && q[ir].id == 0);
        chk1("rsp1_valid", rsp1_valid_o, (ir >= 0) && q[ir].id == 1);
        if (ir >= 0 && q[ir].id == 0) begin
            chk32("rsp0_rdata", rsp0_rdata_o, q[ir].rdata);
            chk1("rsp0_err", rsp0_err_o, q[ir].err);
            chk32("rsp1_rdata_quiet", rsp1_rdata_o, 32'h0);
            chk1("rsp1_err_quiet", rsp1_err_o, 1'b0);
        end
        if (ir >= 0 && q[ir].id == 1) begin
            chk32("rsp1_rdata", rsp1_rdata_o, q[ir].rdata);
            chk1("rsp1_err", rsp1_err_o, q[ir].err);
            chk32("rsp0_rdata_quiet", rsp0_rdata_o, 32'h0);
            chk1("rsp0_err_quiet", rsp0_err_o, 1'b0);
        end
        if (req0_valid_i && req0_ready_o) hs_log.push_back('{0, cyc});
        if (req1_valid_i && req1_ready_o) hs_log.push_back('{1, cyc});
        if (rsp0_valid_o || rsp1_valid_o) begin
            last_rsp_id = rsp1_valid_o ? 1 : 0;
            last_rdata  = rsp1_valid_o ? rsp1_rdata_o : rsp0_rdata_o;
            last_err    = rsp1_valid_o ? rsp1_err_o : rsp0_err_o;
            rsp_log.push_back('{last_rsp_id, cyc});
            rsp_cnt++;
        end
    endtask

    task automatic advance(input bit hs, input txn_t nt);
        int w;
        if (rstn_i) begin
            foreach (q[i]) begin
                if (q[i].acc_cyc == cyc) begin
                    w = int'(q[i].addr[9:2]);
                    if (m_illegal(q[i].size, q[i].addr)) begin
                        q[i].err = 1'b1; q[i].rdata = 32'h0;
                    end else if (q[i].we) begin
                        ref_mem[w] = merge(ref_mem[w], q[i].wdata, m_mask(q[i].size));
                        q[i].err = 1'b0; q[i].rdata = 32'h0;
                    end else begin
                        q[i].err = 1'b0; q[i].rdata = ref_mem[w];
                    end
                end
            end
            if (hs) begin
                q.push_back(nt);
                m_last = (nt.id == 1);
            end
            while (q.size() > 0 && q[0].acc_cyc + 1 <= cyc) void'(q.pop_front());
        end
        cyc++;
    endtask

    initial begin : compare
        bit   hs;
        txn_t nt;
        forever begin
            @(negedge clk);
            #2;
            check_cycle(hs, nt);
            @(posedge clk);
            advance(hs, nt);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic drive_idle();
        req0_valid_i = 0; req1_valid_i = 0;
    endtask

    task automatic set_req(input int id, input logic [31:0] addr, input bit we,
                           input logic [1:0] size, input logic [31:0] wdata);
        if (id == 0) begin
            req0_addr_i = addr; req0_we_i = we; req0_size_i = size; req0_wdata_i = wdata; req0_valid_i = 1;
        end else begin
            req1_addr_i = addr; req1_we_i = we; req1_size_i = size; req1_wdata_i = wdata; req1_valid_i = 1;
        end
    endtask

    // Present one request until accepted; returns in the following (ACCESS) cycle with valid dropped.
    task automatic issue(input int id, input logic [31:0] addr, input bit we,
                         input logic [1:0] size, input logic [31:0] wdata);
        bit got;
        got = 0;
        @(negedge clk);
        drive_idle();
        set_req(id, addr, we, size, wdata);
        for (int k = 0; k < 20; k++) begin
            #1;
            if ((id == 0 && req0_ready_o) || (id == 1 && req1_ready_o)) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk1("issue_accepted", got, 1'b1);
        @(negedge clk);
        drive_idle();
    endtask

    task automatic txn(input int id, input logic [31:0] addr, input bit we,
                       input logic [1:0] size, input logic [31:0] wdata);
        int c0;
        c0 = rsp_cnt;
        issue(id, addr, we, size, wdata);
        repeat (2) @(negedge clk);
        chk32("rsp_count", 32'(rsp_cnt - c0), 32'd1);
        chk32("rsp_owner", 32'(last_rsp_id), 32'(id));
    endtask

    initial begin : stim
        int exp_ids [4];
        int c0;
        exp_ids = '{0, 1, 0, 1};
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        mem_init = 1;
        rstn_i   = 0;
        rsp_cnt  = 0;
        m_last   = 1;
        set_req(0, 32'h0, 1'b0, 2'd2, 32'h0);
        set_req(1, 32'h4, 1'b0, 2'd2, 32'h0);
        repeat (2) @(negedge clk);
        mem_init = 0;
        @(negedge clk);
        #1;
        chk1("reset_ready0_lit", req0_ready_o, 1'b0);
        chk1("reset_ram_en_lit", ram_en_o, 1'b0);
        chk1("reset_rsp0_lit", rsp0_valid_o, 1'b0);

        // Both requesters valid continuously from reset release.
        @(negedge clk);
        hs_log.delete(); rsp_log.delete();
        rstn_i = 1;
        repeat (9) @(negedge clk);
        drive_idle();
        repeat (3) @(negedge clk);
        chk1("rr_grant_count", hs_log.size() >= 4, 1'b1);
        chk1("rr_rsp_count", rsp_log.size() >= 4, 1'b1);
        if (hs_log.size() >= 4 && rsp_log.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk32("rr_grant_id", 32'(hs_log[k].id), 32'(exp_ids[k]));
                chk32("rr_rsp_id", 32'(rsp_log[k].id), 32'(exp_ids[k]));
                chk32("rr_rsp_latency", 32'(rsp_log[k].c - hs_log[k].c), 32'd2);
            end
        end

        // Word store, then read back.
        txn(0, 32'h40, 1'b1, 2'd2, 32'hDEAD_BEEF);
        chk32("word_store_we", 32'(acc_we_seen), 32'hF);
        chk1("word_store_err", last_err, 1'b0);
        txn(0, 32'h40, 1'b0, 2'd2, 32'h0);
        chk32("word_readback", last_rdata, 32'hDEAD_BEEF);

        // Byte store into an existing word.
        txn(1, 32'h44, 1'b1, 2'd0, 32'h0000_00AB);
        chk32("byte_store_we", 32'(acc_we_seen), 32'h1);
        txn(1, 32'h44, 1'b0, 2'd2, 32'h0);
        chk32("byte_readback", last_rdata, 32'h1122_33AB);

        // Misaligned word load by requester 1.
        txn(1, 32'h42, 1'b0, 2'd2, 32'h0);
        chk1("misalign_en", acc_en_seen, 1'b0);
        chk1("misalign_err", last_err, 1'b1);
        chk32("misalign_rdata", last_rdata, 32'h0);

        // Illegal size store leaves memory alone.
        txn(0, 32'h48, 1'b1, 2'd3, 32'hFFFF_FFFF);
        chk1("size11_err", last_err, 1'b1);
        chk32("size11_we", 32'(acc_we_seen), 32'h0);
        chk32("size11_ram", env_ram[18], 32'hCAFE_F00D);

        // Reset during the ACCESS cycle of a store.
        issue(0, 32'h80, 1'b1, 2'd2, 32'h1234_5678);
        rstn_i = 0;
        set_req(0, 32'h0, 1'b0, 2'd2, 32'h0);
        set_req(1, 32'h4, 1'b0, 2'd2, 32'h0);
        c0 = rsp_cnt;
        #1;
        chk1("midrst_ram_en", ram_en_o, 1'b0);
        chk32("midrst_ram_we", 32'(ram_we_o), 32'h0);
        chk1("midrst_ready1", req1_ready_o, 1'b0);
        repeat (2) @(negedge clk);
        chk32("midrst_no_rsp", 32'(rsp_cnt - c0), 32'd0);
        chk32("midrst_ram_word", env_ram[32], 32'h55AA_55AA);
        hs_log.delete();
        rstn_i = 1;
        @(negedge clk);
        drive_idle();
        chk1("post_rst_hs", hs_log.size() >= 1, 1'b1);
        if (hs_log.size() >= 1) chk32("post_rst_tie_winner", 32'(hs_log[0].id), 32'd0);
        repeat (3) @(negedge clk);

        // Randomized traffic, with occasional reset pulses.
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            rstn_i       = ($urandom_range(0, 149) != 0);
            req0_valid_i = ($urandom_range(0, 3) != 0);
            req1_valid_i = ($urandom_range(0, 3) != 0);
            req0_addr_i  = 32'($urandom_range(0, 63));
            req1_addr_i  = 32'($urandom_range(0, 63));
            req0_we_i    = 1'($urandom_range(0, 1));
            req1_we_i    = 1'($urandom_range(0, 1));
            req0_size_i  = 2'($urandom_range(0, 3));
            req1_size_i  = 2'($urandom_range(0, 3));
            req0_wdata_i = $urandom;
            req1_wdata_i = $urandom;
        end
        @(negedge clk);
        rstn_i = 1;
        drive_idle();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Two-requester arbiter and sequencer for the read/write port B of the shared dual-port RAM. It arbitrates round-robin between the core load/store unit (requester 0) and the program loader/debug master (requester 1), and drives the RAM's enable, byte-write-enable, address and data. It returns the read word plus an error flag to the requester that owns the access. Port A (instruction fetch) is untouched.

## Interface
- Parameters: none; all widths fixed at 32-bit address/data.
- clk  in  1  system clock; everything samples on rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- reqN_valid_i  in  1  request valid, N ∈ {0,1}
- reqN_ready_o  out  1  request accepted when valid & ready
- reqN_addr_i  in  32  byte address
- reqN_we_i  in  1  1 = store, 0 = load
- reqN_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- reqN_wdata_i  in  32  store data, low lanes used for byte/half
- rspN_valid_o  out  1  one-cycle response pulse
- rspN_rdata_o  out  32  RAM word read during the access; 0 on error or store
- rspN_err_o  out  1  access rejected; qualified by rspN_valid_o
- ram_en_o  out  1  port-B enable
- ram_we_o  out  4  byte write enables
- ram_addr_o  out  32  byte address; the RAM drops the low 2 bits
- ram_din_o  out  32  write data
- ram_dout_i  in  32  combinational read data from port B

## Operation
- FSM states: IDLE, ACCESS, RESP.
- Arbitration happens in IDLE and RESP. The winner's ready is high and the loser's ready is low; in ACCESS both readies are low.
- Round-robin: the `last` register resets to 1, so requester 0 wins the first tie. On a tie, the requester not in `last` wins. `last` updates only on a handshake.
- On handshake: latch addr, we, size, wdata and owner id, then go to ACCESS. With no handshake, go to IDLE.
- ACCESS: outputs are driven only from the latched registers, with no combinational path from the req inputs.
  - Legal access: ram_en_o=1.
  - ram_we_o: store word 1111, store half 0011, store byte 0001, load 0000. Stores always write the low lanes of the addressed word.
  - rdata register captures ram_dout_i for loads and is cleared for stores.
- Error: size=11, or half with addr[0]=1, or word with addr[1:0]≠00.
  - In ACCESS: ram_en_o=0, ram_we_o=0000, err register set, rdata register 0.
- RESP: rsp{owner}_valid_o=1 for exactly one cycle with the latched rdata/err. The other requester's rsp outputs stay 0.
- Reset values: every output and register is 0 and the state is IDLE. Assertion mid-operation discards the pending access immediately. No response is issued, and a RAM write not yet clocked is lost.

## Timing
- Handshake at edge T. ACCESS is the cycle after T, and its RAM write commits at the edge ending ACCESS. rsp_valid is high in the following cycle: load-to-response latency 2 cycles.
- Throughput: one access per 2 cycles, because a new request may be accepted in the RESP cycle.
- Read-after-write back-to-back: the write commits before the next ACCESS, so the load returns the new data.
- rdata/err are held stable only while rsp_valid_o is high. Responses must be consumed the same cycle, with no back-pressure.
- valid may drop before ready: no handshake, no state change.

## Structure
- The shared package `panda_mem_pkg` holds:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD).
  - WE_WORD/WE_HALF/WE_BYTE 4-bit constants.
  - FSM state typedef.
- Sub-module `rr_arb2`: two-way round-robin pick with a `last` register and an update-on-grant input. The FSM, latching and lane logic live in the top module.

## Test plan
- Single word store by requester 0: addr 0x40, data 0xDEADBEEF, size 10.
  - ACCESS cycle: ram_we_o=1111.
  - Following cycle: rsp0_valid=1, err=0.
  - A later load of 0x40 returns 0xDEADBEEF.
- Byte store 0xAB to addr 0x44 over existing 0x11223344:
  - ram_we_o=0001.
  - Read-back returns 0x112233AB.
- Both requesters valid continuously from reset:
  - Grants alternate 0,1,0,1.
  - Each rsp arrives 2 cycles after its handshake.
  - The other requester's ready is low during each ACCESS.
- Misaligned word load at 0x42 by requester 1:
  - ram_en_o stays 0.
  - rsp1_valid=1, rsp1_err=1, rdata=0.
- Size 11 store: no RAM write (RAM contents unchanged), err=1.
- rstn_i asserted during ACCESS of a store:
  - All outputs 0 and no rsp pulse.
  - The RAM word is unchanged.
  - The first request after release is accepted normally, and requester 0 wins a tie.
